pkt_eject_port: RTL

PKT_EJECT_PORT -- requirements
Module: pkt_eject_port

---
 rtl/pkt_eject_port.sv | 96 +++++++++
 1 files changed

// File: rtl/pkt_eject_port.sv
// Eject port: buffers packets addressed to NODE_ID for the local core, counts misroutes and deliveries.
// Latency: one cycle from accept to core_valid; head payload is read straight from storage.
// Backpressure: pkt_in_ready drops when the buffer is full, or while in reset; a same-cycle pop does not reopen it.
module pkt_eject_port #(
    parameter int NUM_PROC = 4,
    parameter int NODE_ID  = 0,
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 48,
    localparam int ID_W    = $clog2(NUM_PROC),
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_in_valid,
    input  logic [ID_W-1:0]   pkt_in_src,
    input  logic [ID_W-1:0]   pkt_in_dest,
    input  logic [ADDR_W-1:0] pkt_in_addr,
    output logic              pkt_in_ready,
    output logic              core_valid,
    output logic [ID_W-1:0]   core_src,
    output logic [ADDR_W-1:0] core_addr,
    input  logic              core_ready,
    output logic [CNT_W-1:0]  occupancy,
    output logic [15:0]       misroute_cnt,
    output logic [31:0]       delivered_cnt
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [ID_W-1:0]   src;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] occ;
    logic             accept;
    logic             dest_match;
    logic             store;
    logic             misroute;
    logic             pop;

    assign occupancy    = occ;
    assign pkt_in_ready = (occ != CNT_W'(DEPTH)) && !rst;
    assign core_valid   = (occ != '0) && !rst;

    assign accept     = pkt_in_valid && pkt_in_ready;
    assign dest_match = (pkt_in_dest == ID_W'(NODE_ID));
    assign store      = accept && dest_match;
    assign misroute   = accept && !dest_match;
    assign pop        = core_valid && core_ready;

    // Payload is forced to zero whenever there is no valid head so idle outputs are deterministic.
    always_comb begin
        core_src  = '0;
        core_addr = '0;
        if (core_valid) begin
            core_src  = mem[rd_ptr].src;
            core_addr = mem[rd_ptr].addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
            misroute_cnt  <= '0;
            delivered_cnt <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr        <= rd_ptr + 1'b1;
                delivered_cnt <= delivered_cnt + 32'd1;
            end
            case ({store, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            if (misroute && (misroute_cnt != 16'hFFFF)) begin
                misroute_cnt <= misroute_cnt + 16'd1;
            end
        end
    end

    // Storage needs no reset: entries are only observable through occ, which is reset.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr] <= '{src: pkt_in_src, addr: pkt_in_addr};
        end
    end
endmodule
